lfsr12_stream_checker: RTL



---
 rtl/lfsr12_stream_checker_if.sv | 22 ++
 rtl/lfsr12_stream_checker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/lfsr12_stream_checker_if.sv
// Word stream into the LFSR checker and its lock/error status back out.
interface lfsr12_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             data_valid_i;
    logic [11:0]      data_in_i;
    logic             clear_cnt_i;
    logic             locked_o;
    logic             error_pulse_o;
    logic [CNT_W-1:0] error_count_o;
    logic [CNT_W-1:0] word_count_o;

    modport master (
        output data_valid_i, data_in_i, clear_cnt_i,
        input  locked_o, error_pulse_o, error_count_o, word_count_o
    );

    modport slave (
        input  data_valid_i, data_in_i, clear_cnt_i,
        output locked_o, error_pulse_o, error_count_o, word_count_o
    );
endinterface

// File: rtl/lfsr12_stream_checker.sv
// Self-synchronising checker for the 12-bit Galois LFSR stream; all flags registered, 1 cycle after the word.
// No backpressure: a word is consumed in every DATA_VALID cycle.
module lfsr12_stream_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    lfsr12_stream_checker_if.slave  bus
);
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_t           state_q, state_d;
    logic             seeded_q, seeded_d;
    logic [11:0]      expected_q, expected_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             err_ev;
    logic             word_ev;

    function automatic logic [11:0] lfsr_next(input logic [11:0] w);
        return {w[10:0], 1'b0} ^ (w[11] ? 12'h093 : 12'h000);
    endfunction

    // Clear takes effect before the increment, so a same-cycle event leaves the count at 1.
    function automatic logic [CNT_W-1:0] cnt_bump(input logic [CNT_W-1:0] c,
                                                  input logic clr, input logic ev);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : c;
        if (ev && (base != '1)) begin
            return base + CNT_W'(1);
        end
        return base;
    endfunction

    always_comb begin
        state_d     = state_q;
        seeded_d    = seeded_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        err_ev      = 1'b0;
        word_ev     = 1'b0;

        if (bus.data_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (seeded_q && (bus.data_in_i == expected_q)) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        expected_d  = lfsr_next(bus.data_in_i);
                        if ((match_cnt_q + 4'd1) == LOCK_N) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        // Reseed from the received word; all-zero is the LFSR lock-up value and never seeds.
                        match_cnt_d = 4'd0;
                        if (bus.data_in_i != 12'h000) begin
                            expected_d = lfsr_next(bus.data_in_i);
                            seeded_d   = 1'b1;
                        end else begin
                            seeded_d   = 1'b0;
                        end
                    end
                end
                ST_LOCKED: begin
                    word_ev    = 1'b1;
                    expected_d = lfsr_next(expected_q);
                    if (bus.data_in_i == expected_q) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_ev      = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_cnt_q + 4'd1;
                        if ((miss_cnt_q + 4'd1) == LOSS_N) begin
                            state_d     = ST_HUNT;
                            seeded_d    = 1'b0;
                            match_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        err_cnt_d  = cnt_bump(err_cnt_q, bus.clear_cnt_i, err_ev);
        word_cnt_d = cnt_bump(word_cnt_q, bus.clear_cnt_i, word_ev);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_HUNT;
            seeded_q    <= 1'b0;
            expected_q  <= 12'h000;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            seeded_q    <= seeded_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.locked_o      = (state_q == ST_LOCKED);
    assign bus.error_pulse_o = err_pulse_q;
    assign bus.error_count_o = err_cnt_q;
    assign bus.word_count_o  = word_cnt_q;
endmodule
